// File: rtl/ice40_pll_pkg.sv
// ice40_pll_pkg
//   Shared constants and the elaboration-time configuration checker for the
//   iCE40 SB_PLL40_CORE behavioural model.
//   Contents:
//     - PFD / VCO frequency limits, DIVQ range, DIVF ceilings per feedback mode
//     - pll_cfg_t  : {valid, fout_hz} result record
//     - pll_check(): constant function that validates a divider set and
//                    returns the emulated output frequency
package ice40_pll_pkg;

  localparam logic [63:0] PFD_MIN_HZ      = 64'd10_000_000;
  localparam logic [63:0] PFD_MAX_HZ      = 64'd133_000_000;
  localparam logic [63:0] VCO_MIN_HZ      = 64'd533_000_000;
  localparam logic [63:0] VCO_MAX_HZ      = 64'd1_066_000_000;
  localparam logic [63:0] DIVQ_MIN        = 64'd1;
  localparam logic [63:0] DIVQ_MAX        = 64'd6;
  localparam logic [63:0] DIVF_MAX_SIMPLE = 64'd127;
  localparam logic [63:0] DIVF_MAX_OTHER  = 64'd63;
  localparam logic [63:0] FILTER_MAX      = 64'd7;

  typedef struct packed {
    logic        valid;
    logic [63:0] fout_hz;
  } pll_cfg_t;

  // All arithmetic is 64-bit so REF_HZ * multiplier never overflows.
  function automatic pll_cfg_t pll_check(
    input logic [63:0] ref_hz,
    input logic [63:0] divr,
    input logic [63:0] divf,
    input logic [63:0] divq,
    input logic [63:0] filt,
    input logic        simple_fb
  );
    logic [63:0] pfd;
    logic [63:0] vco;
    logic [63:0] divf_max;
    pll_cfg_t    res;
    pfd      = ref_hz / (divr + 64'd1);
    vco      = pfd * (divf + 64'd1);
    divf_max = simple_fb ? DIVF_MAX_SIMPLE : DIVF_MAX_OTHER;
    res.valid = (pfd  >= PFD_MIN_HZ) && (pfd  <= PFD_MAX_HZ) &&
                (vco  >= VCO_MIN_HZ) && (vco  <= VCO_MAX_HZ) &&
                (divq >= DIVQ_MIN)   && (divq <= DIVQ_MAX)   &&
                (divf <= divf_max)   && (filt <= FILTER_MAX);
    res.fout_hz = vco >> divq;
    return res;
  endfunction

endpackage

// File: rtl/ice40_pll_nco.sv
// ice40_pll_nco
//   Phase accumulator that emulates the PLL output frequency as the rational
//   ratio M_VAL/N_VAL of the reference clock.
//   Ports:
//     i_clk      reference clock
//     i_rst      synchronous active-high reset (clears all state)
//     i_en       advance the accumulator this edge (otherwise hold)
//     o_cycles   emulated output cycles, wraps modulo 2^32
//     o_out      registered output level (accumulator in upper half)
module ice40_pll_nco
  import ice40_pll_pkg::*;
#(
  parameter int unsigned M_VAL = 35,
  parameter int unsigned N_VAL = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [31:0] o_cycles,
  output logic        o_out
);

  localparam logic [32:0] M_W    = 33'(M_VAL);
  localparam logic [32:0] N_W    = 33'(N_VAL);
  localparam logic [31:0] HALF_N = 32'(N_VAL / 2);

  logic [31:0] r_acc;
  logic [31:0] r_cycles;
  logic        r_out;
  logic [32:0] w_sum;
  logic [31:0] w_acc_next;
  logic [31:0] w_carry;

  // The carry can exceed one when M > N, so a true divide is used; N is a
  // constant, so this reduces to fixed logic.
  assign w_sum      = 33'(r_acc) + M_W;
  assign w_acc_next = 32'(w_sum % N_W);
  assign w_carry    = 32'(w_sum / N_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_cycles <= '0;
      r_out    <= 1'b0;
    end else if (i_en) begin
      r_acc    <= w_acc_next;
      r_cycles <= r_cycles + w_carry;
      r_out    <= (w_acc_next >= HALF_N);
    end
  end

  assign o_cycles = r_cycles;
  assign o_out    = r_out;

endmodule

// File: rtl/ice40_pll_core_model.sv
// ice40_pll_core_model
//   Cycle-level model of the iCE40 SB_PLL40_CORE: static configuration check,
//   lock acquisition, bypass, and output-frequency emulation.
//   Ports:
//     REFERENCECLK  reference clock (only clock)
//     RESETB        synchronous reset, active-high despite the name
//     BYPASS        1 = PLLOUTCORE follows REFERENCECLK directly
//     PLLOUTCORE    modelled PLL output
//     LOCK          PLL locked
//     CFG_ERR       static divider configuration is outside device limits
//     OUT_CYCLES    emulated output cycles since lock (wraps at 2^32)
module ice40_pll_core_model
  import ice40_pll_pkg::*;
#(
  parameter string           FEEDBACK_PATH = "SIMPLE",
  parameter int unsigned     DIVR          = 4'b0000,
  parameter int unsigned     DIVF          = 7'b0100010,
  parameter int unsigned     DIVQ          = 3'b010,
  parameter int unsigned     FILTER_RANGE  = 3'b001,
  parameter longint unsigned REF_HZ        = 16000000,
  parameter int unsigned     LOCK_CYCLES   = 16
) (
  input  logic        REFERENCECLK,
  input  logic        RESETB,
  input  logic        BYPASS,
  output logic        PLLOUTCORE,
  output logic        LOCK,
  output logic        CFG_ERR,
  output logic [31:0] OUT_CYCLES
);

  localparam bit       SIMPLE_FB = (FEEDBACK_PATH == "SIMPLE");
  localparam pll_cfg_t CFG       = pll_check(64'(REF_HZ), 64'(DIVR), 64'(DIVF),
                                             64'(DIVQ), 64'(FILTER_RANGE),
                                             SIMPLE_FB);

  localparam int unsigned M_VAL  = DIVF + 1;
  localparam logic [63:0] N_WIDE = (64'(DIVR) + 64'd1) << DIVQ;
  // Absurd DIVQ values can shift N out of range; keep the divisor non-zero so
  // elaboration stays legal (CFG_ERR is raised for those anyway).
  localparam int unsigned N_VAL  = (N_WIDE == 64'd0 || N_WIDE > 64'h7FFF_FFFF) ?
                                   1 : int'(N_WIDE[31:0]);

  localparam int unsigned          CNT_W  = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LK = CNT_W'(LOCK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_lock;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_nco_en;
  logic             w_nco_out;

  assign CFG_ERR = ~CFG.valid;

  // Saturating lock counter; LOCK is registered on the edge the count lands
  // on LOCK_CYCLES. Bypass or a bad configuration keeps it cleared.
  assign w_cnt_next = (r_cnt == CNT_LK) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge REFERENCECLK) begin
    if (RESETB) begin
      r_cnt  <= '0;
      r_lock <= 1'b0;
    end else if (BYPASS || CFG_ERR) begin
      r_cnt  <= '0;
      r_lock <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_lock <= (w_cnt_next == CNT_LK);
    end
  end

  // The accumulator advances only on edges where lock was already held.
  assign w_nco_en = r_lock & ~BYPASS;

  ice40_pll_nco #(
    .M_VAL (M_VAL),
    .N_VAL (N_VAL)
  ) u_nco (
    .i_clk    (REFERENCECLK),
    .i_rst    (RESETB),
    .i_en     (w_nco_en),
    .o_cycles (OUT_CYCLES),
    .o_out    (w_nco_out)
  );

  // LOCK drops combinationally with BYPASS so it never overlaps the
  // pass-through clock.
  assign LOCK       = r_lock & ~BYPASS;
  assign PLLOUTCORE = BYPASS ? REFERENCECLK : (r_lock & w_nco_out);

endmodule

// File: tb/tb_ice40_pll_core_model.sv
module tb_ice40_pll_core_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic byp = 1'b0;
  logic byp_off = 1'b0;

  logic        out_d, lock_d, err_d;
  logic [31:0] oc_d;
  logic        out_f, lock_f, err_f;
  logic [31:0] oc_f;
  logic        out_q, lock_q, err_q;
  logic [31:0] oc_q;
  logic        out_l, lock_l, err_l;
  logic [31:0] oc_l;
  logic        out_g, lock_g, err_g;
  logic [31:0] oc_g;

  ice40_pll_core_model dut (
    .REFERENCECLK(clk), .RESETB(rst), .BYPASS(byp),
    .PLLOUTCORE(out_d), .LOCK(lock_d), .CFG_ERR(err_d), .OUT_CYCLES(oc_d));

  ice40_pll_core_model #(.DIVF(20)) dut_lowvco (
    .REFERENCECLK(clk), .RESETB(rst), .BYPASS(byp_off),
    .PLLOUTCORE(out_f), .LOCK(lock_f), .CFG_ERR(err_f), .OUT_CYCLES(oc_f));

  ice40_pll_core_model #(.DIVQ(0)) dut_divq0 (
    .REFERENCECLK(clk), .RESETB(rst), .BYPASS(byp_off),
    .PLLOUTCORE(out_q), .LOCK(lock_q), .CFG_ERR(err_q), .OUT_CYCLES(oc_q));

  ice40_pll_core_model #(.FEEDBACK_PATH("DELAY"), .DIVF(100)) dut_delay (
    .REFERENCECLK(clk), .RESETB(rst), .BYPASS(byp_off),
    .PLLOUTCORE(out_l), .LOCK(lock_l), .CFG_ERR(err_l), .OUT_CYCLES(oc_l));

  ice40_pll_core_model #(.DIVR(1), .DIVF(100), .REF_HZ(20000000)) dut_good (
    .REFERENCECLK(clk), .RESETB(rst), .BYPASS(byp_off),
    .PLLOUTCORE(out_g), .LOCK(lock_g), .CFG_ERR(err_g), .OUT_CYCLES(oc_g));

  typedef struct {
    bit          rst;
    bit          byp;
    int unsigned n;
    bit          exp_lock;
    int unsigned exp_oc;
    bit          chk_pat;
    logic [7:0]  exp_pat;
  } vec_t;

  typedef struct {
    bit          lock;
    int unsigned oc;
    bit          out;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model of the default configuration: M=35, N=4, 16 lock edges.
  int unsigned m_cnt = 0, m_acc = 0, m_oc = 0;
  bit          m_lock = 0, m_ob = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_u32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit b);
    int unsigned s;
    if (r) begin
      m_cnt = 0; m_lock = 0; m_acc = 0; m_oc = 0; m_ob = 0;
    end else begin
      if (m_lock && !b) begin
        s     = m_acc + 35;
        m_acc = s % 4;
        m_oc  = m_oc + s / 4;
        m_ob  = (m_acc >= 2);
      end
      if (b) begin
        m_cnt = 0; m_lock = 0;
      end else begin
        if (m_cnt < 16) m_cnt++;
        m_lock = (m_cnt == 16);
      end
    end
  endtask

  task automatic run_cycle(input bit r, input bit b, output logic out_bit);
    exp_t e;
    rst = r;
    byp = b;
    model_step(r, b);
    e.lock = m_lock && !b;
    e.oc   = m_oc;
    e.out  = b ? 1'b1 : (m_lock & m_ob);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk_bit("lock", lock_d, e.lock);
      chk_u32("out_cycles", oc_d, e.oc);
      chk_bit("pllout", out_d, e.out);
    end
    chk_bit("lowvco_lock", lock_f, 1'b0);
    chk_u32("lowvco_oc", oc_f, 32'd0);
    chk_bit("lowvco_out", out_f, 1'b0);
    out_bit = out_d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    logic ob;
    logic [7:0] pat;
    tbl[0]  = '{1, 0,  3, 0,   0, 0, 8'h00};
    tbl[1]  = '{0, 0, 15, 0,   0, 0, 8'h00};
    tbl[2]  = '{0, 0,  1, 1,   0, 0, 8'h00};
    tbl[3]  = '{0, 0,  4, 1,  35, 1, 8'b0000_1100};
    tbl[4]  = '{0, 0,  4, 1,  70, 0, 8'h00};
    tbl[5]  = '{1, 0,  1, 0,   0, 0, 8'h00};
    tbl[6]  = '{0, 0, 16, 1,   0, 0, 8'h00};
    tbl[7]  = '{0, 0,  8, 1,  70, 0, 8'h00};
    tbl[8]  = '{0, 1,  5, 0,  70, 0, 8'h00};
    tbl[9]  = '{0, 0, 15, 0,  70, 0, 8'h00};
    tbl[10] = '{0, 0,  1, 1,  70, 0, 8'h00};
    tbl[11] = '{0, 0,  4, 1, 105, 0, 8'h00};
    tbl[12] = '{0, 0, 24, 1, 315, 0, 8'h00};

    #1;
    chk_bit("cfg_err_default", err_d, 1'b0);

    for (int v = 0; v < 13; v++) begin
      pat = '0;
      for (int c = 0; c < int'(tbl[v].n); c++) begin
        run_cycle(tbl[v].rst, tbl[v].byp, ob);
        pat = {pat[6:0], ob};
      end
      chk_bit($sformatf("seg%0d_lock", v), lock_d, tbl[v].exp_lock);
      chk_u32($sformatf("seg%0d_oc", v), oc_d, tbl[v].exp_oc);
      if (tbl[v].chk_pat)
        chk_u32($sformatf("seg%0d_pattern", v), 32'(pat), 32'(tbl[v].exp_pat));
    end

    // Bypass pass-through: output follows both clock phases, LOCK low.
    rst = 1'b0;
    byp = 1'b1;
    #1;
    chk_bit("bypass_high", out_d, 1'b1);
    chk_bit("bypass_lock", lock_d, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_bit("bypass_low", out_d, 1'b0);
      @(posedge clk);
      model_step(1'b0, 1'b1);
      #1;
      chk_bit("bypass_high", out_d, 1'b1);
    end
    chk_u32("bypass_hold_oc", oc_d, 32'd315);
    byp = 1'b0;

    chk_bit("cfg_err_lowvco", err_f, 1'b1);
    chk_bit("cfg_err_divq0", err_q, 1'b1);
    chk_bit("lock_divq0", lock_q, 1'b0);
    chk_bit("cfg_err_delay_divf100", err_l, 1'b1);
    chk_bit("lock_delay_divf100", lock_l, 1'b0);
    chk_bit("cfg_err_vco1010", err_g, 1'b0);
    chk_bit("lock_vco1010", lock_g, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ice40_pll_core_model.md
Name: ice40_pll_core_model

Overview:
- Synthesizable, cycle-level behavioural model of the iCE40 SB_PLL40_CORE primitive, used in simulation and on non-iCE40 targets wherever the `pll` wrapper instantiates the hard PLL.
- Checks the static divider configuration against iCE40 limits.
- Models lock acquisition and bypass.
- Emulates the output frequency with a phase accumulator clocked by the reference clock.

Parameters:
- FEEDBACK_PATH, "SIMPLE", feedback mode. "SIMPLE" allows DIVF up to 127; any other mode limits DIVF to 63.
- DIVR, 4'b0000, reference divider; PFD divisor = DIVR+1.
- DIVF, 7'b0100010, feedback divider; multiplier M = DIVF+1.
- DIVQ, 3'b010, output divider exponent; valid range 1..6.
- FILTER_RANGE, 3'b001, loop-filter setting; range-checked only, no functional effect.
- REF_HZ, 16000000, reference frequency in Hz, used for PFD/VCO range checks.
- LOCK_CYCLES, 16, reference cycles from reset release to LOCK.

Ports:
- REFERENCECLK  in  1  reference clock; the only clock.
- RESETB  in  1  reset; synchronous, active-high (1 = in reset; name kept for primitive compatibility).
- BYPASS  in  1  1 = PLLOUTCORE driven directly from REFERENCECLK.
- PLLOUTCORE  out  1  modelled PLL output.
- LOCK  out  1  PLL locked.
- CFG_ERR  out  1  static configuration invalid.
- OUT_CYCLES  out  32  count of emulated output cycles since lock.

Behaviour:
- Derived constants (elaboration time):
  - f_pfd = REF_HZ/(DIVR+1)
  - f_vco = f_pfd*(DIVF+1)
  - N = (DIVR+1)<<DIVQ
  - emulated fout = f_vco>>DIVQ
- CFG_ERR = 1 (constant) if any of the following holds:
  - f_pfd outside 10e6..133e6
  - f_vco outside 533e6..1066e6
  - DIVQ outside 1..6
  - DIVF > DIVF_MAX (127 SIMPLE, 63 otherwise)
  - FILTER_RANGE > 7
- Use 64-bit arithmetic for all derived-constant computation.
- Reset (RESETB=1 at a rising edge): lock counter=0, LOCK=0, accumulator acc=0, OUT_CYCLES=0, PLLOUTCORE register=0.
- Reset mid-operation has the same effect and always takes priority.
- Lock counter:
  - increments each edge while RESETB=0, BYPASS=0 and CFG_ERR=0;
  - saturates at LOCK_CYCLES;
  - LOCK register=1 once the counter reaches LOCK_CYCLES, i.e. LOCK rises on the LOCK_CYCLES-th edge after release;
  - CFG_ERR=1 holds LOCK at 0 permanently.
- BYPASS=1:
  - PLLOUTCORE = REFERENCECLK (combinational mux);
  - LOCK forced 0, lock counter cleared, acc and OUT_CYCLES hold;
  - on BYPASS falling, lock is reacquired after LOCK_CYCLES edges.
- Locked operation, on each edge where LOCK=1 before the edge:
  - s = acc+M; acc ← s mod N; OUT_CYCLES ← OUT_CYCLES + s div N;
  - OUT_CYCLES wraps modulo 2^32;
  - registered PLLOUTCORE ← (acc_next >= N/2).
  - Net result: after K locked edges, OUT_CYCLES = floor(K*M/N).
- When not locked and not bypassed, PLLOUTCORE = 0.
- Ratios M/N > 0.5 alias on PLLOUTCORE; OUT_CYCLES is the authoritative frequency observable.

Decomposition:
- Package ice40_pll_pkg holds:
  - constants PFD_MIN_HZ/PFD_MAX_HZ (10e6/133e6), VCO_MIN_HZ/VCO_MAX_HZ (533e6/1066e6), DIVQ_MIN/MAX (1/6), DIVF_MAX_SIMPLE/OTHER (127/63);
  - a constant function returning {valid, fout}.
- One sub-module, ice40_pll_nco: accumulator plus OUT_CYCLES counter with an enable input.

Test Plan:
- Defaults (16 MHz, DIVR0/DIVF34/DIVQ2): RESETB=1 for 3 edges, then 0 → CFG_ERR=0, LOCK=0 for 15 edges, LOCK=1 after the 16th.
- Defaults, locked: after 4 locked edges OUT_CYCLES=35, after 8 = 70; acc sequence 3,2,1,0; PLLOUTCORE 1,1,0,0.
- DIVF=20 (VCO 336 MHz) → CFG_ERR=1, LOCK stays 0 for 100 edges, OUT_CYCLES=0, PLLOUTCORE=0. Separately, DIVQ=0 → CFG_ERR=1.
- Locked, BYPASS=1 for 5 edges → PLLOUTCORE mirrors REFERENCECLK, LOCK=0, OUT_CYCLES holds. BYPASS=0 → LOCK back after 16 edges, counting resumes from the held value.
- Locked with OUT_CYCLES=70, RESETB=1 for 1 edge → LOCK=0, OUT_CYCLES=0, PLLOUTCORE=0 the next cycle; relock after 16 edges.
- FEEDBACK_PATH="DELAY", DIVF=100 → CFG_ERR=1. FEEDBACK_PATH="SIMPLE", DIVR=1, DIVF=100, REF_HZ=20e6 (VCO 1010 MHz) → CFG_ERR=0.
